// File: rtl/cmos_capture_if.sv
// cmos_capture_if: sensor inputs, capture controls and packer-side outputs of cmos_capture_ctrl
interface cmos_capture_if;
   logic        cmos_vsync;
   logic        cmos_href;
   logic [7:0]  cmos_data;
   logic        start;
   logic        stop;
   logic        cont;
   logic        cap_de;
   logic [7:0]  cap_data;
   logic        frame_start;
   logic        frame_done;
   logic        busy;
   logic [10:0] line_cnt;
   logic [11:0] byte_cnt;
   logic        size_err;
   modport master (
      output cmos_vsync, cmos_href, cmos_data, start, stop, cont,
      input  cap_de, cap_data, frame_start, frame_done, busy, line_cnt, byte_cnt, size_err
   );
   modport slave (
      input  cmos_vsync, cmos_href, cmos_data, start, stop, cont,
      output cap_de, cap_data, frame_start, frame_done, busy, line_cnt, byte_cnt, size_err
   );
endinterface

// File: rtl/cmos_capture_ctrl.sv
// cmos_capture_ctrl: frame sequencer gating sensor bytes into the packer; define CMOS_SIZE_CHECK_EN for geometry checking
module cmos_capture_ctrl #(
   parameter int SKIP_FRAMES = 10,
   parameter int H_BYTES     = 2560,
   parameter int V_LINES     = 720,
   parameter int VS_POL      = 1
) (
   input logic           pclk,
   input logic           rst_n,
   cmos_capture_if.slave bus
);
   localparam int   SW  = $clog2(SKIP_FRAMES + 2);
   localparam logic POL = 1'(VS_POL);
   typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, DONE} state_t;
   state_t        state_q, state_d;
   logic [SW-1:0] skip_q, skip_d;
   logic          vs_q, href_q, act_q, act_d, stop_q, stop_d;
   logic          cap_de_q, cap_de_d, fst_q, fst_d, fdn_q, fdn_d, err_q, err_d;
   logic [7:0]    data_q, data_d;
   logic [10:0]   line_q, line_d;
   logic [11:0]   byte_q, byte_d;
   logic          vs_act, fs, fe, go, arm, cap, h_rise, h_fall, new_f, end_f, line_bad, frame_bad;
   assign vs_act = bus.cmos_vsync ^ ~POL;
   assign fs     = vs_q & ~vs_act;
   assign fe     = ~vs_q & vs_act;
   assign go     = bus.start & ~bus.stop;
   assign arm    = go & (state_q == IDLE || state_q == DONE);
   // act_q marks "inside a captured frame"; CAPTURE with act_q low is the gap before the next fs
   assign cap    = state_q == CAPTURE && act_q;
   assign h_rise = cap & bus.cmos_href & ~href_q;
   assign h_fall = cap & ~bus.cmos_href & href_q;
   assign new_f  = fs & ~cap & (state_d == CAPTURE);
   assign end_f  = cap & fe;
`ifdef CMOS_SIZE_CHECK_EN
   assign line_bad  = h_fall && byte_q != 12'(H_BYTES);
   assign frame_bad = end_f && line_q != 11'(V_LINES);
`else
   localparam int geom_unused = H_BYTES + V_LINES;
   assign line_bad  = 1'b0;
   assign frame_bad = 1'b0;
`endif
   always_ff @(posedge pclk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         skip_q   <= '0;
         vs_q     <= 1'b0;
         href_q   <= 1'b0;
         act_q    <= 1'b0;
         stop_q   <= 1'b0;
         cap_de_q <= 1'b0;
         data_q   <= '0;
         fst_q    <= 1'b0;
         fdn_q    <= 1'b0;
         line_q   <= '0;
         byte_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         skip_q   <= skip_d;
         vs_q     <= vs_act;
         href_q   <= bus.cmos_href;
         act_q    <= act_d;
         stop_q   <= stop_d;
         cap_de_q <= cap_de_d;
         data_q   <= data_d;
         fst_q    <= fst_d;
         fdn_q    <= fdn_d;
         line_q   <= line_d;
         byte_q   <= byte_d;
         err_q    <= err_d;
      end
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = go ? WAIT_VS : IDLE;
         WAIT_VS: state_d = bus.stop ? IDLE : (fs && skip_q == SW'(SKIP_FRAMES)) ? CAPTURE : WAIT_VS;
         CAPTURE: state_d = (act_q ? fe && (stop_q || bus.stop || !bus.cont) : stop_q || bus.stop) ? DONE : CAPTURE;
         DONE:    state_d = go ? WAIT_VS : DONE;
      endcase
   end
   always_comb begin
      skip_d   = arm ? '0 : (state_q == WAIT_VS && fs) ? skip_q + 1'b1 : skip_q;
      act_d    = state_d == CAPTURE && (new_f || (act_q && !fe));
      stop_d   = state_q == CAPTURE && (stop_q || bus.stop);
      cap_de_d = cap & bus.cmos_href;
      data_d   = cap ? bus.cmos_data : 8'd0;
      fst_d    = new_f;
      fdn_d    = end_f;
      byte_d   = new_f ? '0 : h_rise ? 12'd1 : (cap && bus.cmos_href && !(&byte_q)) ? byte_q + 1'b1 : byte_q;
      line_d   = new_f ? '0 : (h_fall && !(&line_q)) ? line_q + 1'b1 : line_q;
      err_d    = arm ? 1'b0 : err_q | line_bad | frame_bad;
   end
   always_comb begin
      bus.cap_de      = cap_de_q;
      bus.cap_data    = data_q;
      bus.frame_start = fst_q;
      bus.frame_done  = fdn_q;
      bus.busy        = state_q == WAIT_VS || state_q == CAPTURE;
      bus.line_cnt    = line_q;
      bus.byte_cnt    = byte_q;
      bus.size_err    = err_q;
   end
endmodule
